// File: rtl/tx_count_timer.sv
// tx_count_timer: loadable bit-period down-counter for the serial
// transmitter. Counts cen steps from par_ld down to the terminal step.
// Parameters: WIDTH (count width), PRESCALE (cen events per step).
// Optional macro TX_CNT_PRESCALE_EN compiles in the cen prescaler.
// Ports: clk, rst (sync, active-high), ld, cen, abort, mode, par_ld
//   in; count, co, done, busy, load_err out.
module tx_count_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             cen,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] par_ld,
  output logic [WIDTH-1:0] count,
  output logic             co,
  output logic             done,
  output logic             busy,
  output logic             load_err
);

  if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
    $error("tx_count_timer: WIDTH and PRESCALE must be >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             term_q, term_d;
  logic             done_q;
  logic             lerr_q, lerr_d;
  logic             run;
  logic             ld_ok;
  logic             last;
  logic             step;

  assign run   = (state_q == RUN);
  assign last  = (count_q == ONE);
  // abort outranks ld, ld outranks a step: keep the decode one-hot.
  assign ld_ok = ld && (par_ld != '0) && !abort;

`ifdef TX_CNT_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign step = run && cen && !abort && !ld_ok
                && (pre_q == PMAX);
`else
  assign step = run && cen && !abort && !ld_ok;
`endif

  assign lerr_d = ld && (par_ld == '0) && !abort;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    state_d  = state_q;
    term_d   = 1'b0;
`ifdef TX_CNT_PRESCALE_EN
    pre_d = pre_q;
    if (run && cen) begin
      pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
    end
`endif
    unique case (1'b1)
      abort: begin
        count_d = '0;
        state_d = IDLE;
`ifdef TX_CNT_PRESCALE_EN
        pre_d   = '0;
`endif
      end
      ld_ok: begin
        count_d  = par_ld;
        reload_d = par_ld;
        mode_d   = mode;
        state_d  = RUN;
`ifdef TX_CNT_PRESCALE_EN
        pre_d    = '0;
`endif
      end
      step: begin
        if (last) begin
          term_d = 1'b1;
          if (mode_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
`ifdef TX_CNT_PRESCALE_EN
            pre_d   = '0;
`endif
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
      default: ;
    endcase
  end

  // done is registered once more behind the terminal-step flag so it
  // lands one cycle after the count reaches its final value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      term_q   <= 1'b0;
      done_q   <= 1'b0;
      lerr_q   <= 1'b0;
`ifdef TX_CNT_PRESCALE_EN
      pre_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      term_q   <= term_d;
      done_q   <= term_q;
      lerr_q   <= lerr_d;
`ifdef TX_CNT_PRESCALE_EN
      pre_q    <= pre_d;
`endif
    end
  end

  assign count    = count_q;
  assign busy     = run;
  assign co       = run && last;
  assign done     = done_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_tx_count_timer.sv
// Testbench for tx_count_timer: directed vector table plus a few
// multi-cycle sequences; prescaler sequence when the macro is set.
module tb_tx_count_timer;

  logic       clk = 1'b0;
  logic       rst, ld, cen, abort, mode;
  logic [7:0] par_ld;
  logic [7:0] count;
  logic       co, done, busy, load_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  tx_count_timer #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .cen(cen),
    .abort(abort), .mode(mode), .par_ld(par_ld),
    .count(count), .co(co), .done(done),
    .busy(busy), .load_err(load_err)
  );

  typedef struct {
    logic       rst, ld, cen, abort, mode;
    logic [7:0] par;
    logic [7:0] cnt;
    logic       co, done, busy, lerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic r, logic l, logic c, logic a, logic m,
    logic [7:0] p, logic [7:0] n,
    logic o, logic d, logic b, logic e);
    vec_t x;
    x.rst = r; x.ld = l; x.cen = c; x.abort = a;
    x.mode = m; x.par = p; x.cnt = n;
    x.co = o; x.done = d; x.busy = b; x.lerr = e;
    return x;
  endfunction

  task automatic drive(logic r, logic l, logic c,
                       logic a, logic m, logic [7:0] p);
    rst = r; ld = l; cen = c; abort = a;
    mode = m; par_ld = p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] n,
                       logic o, logic d, logic b, logic e);
    logic [11:0] got, exp;
    got = {count, co, done, busy, load_err};
    exp = {n, o, d, b, e};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d co=%b done=%b busy=%b lerr=%b, expected cnt=%0d co=%b done=%b busy=%b lerr=%b",
               name, count, co, done, busy, load_err,
               n, o, d, b, e);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
`ifdef TX_CNT_PRESCALE_EN
    tick; tick;
    check("reset", 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 2);
    tick;
    check("pre_load", 2, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      tick;
      check($sformatf("pre_cen%0d", i),
            8'(2 - i / 4), (i >= 4 && i < 8), 0,
            (i < 8), 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
    check("pre_done", 0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 2);
    tick;
    drive(0, 0, 1, 0, 0, 0);
    tick; tick;
    drive(0, 1, 1, 0, 0, 3);
    tick;
    check("pre_reld", 3, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      tick;
      check($sformatf("pre_win%0d", i),
            (i < 4) ? 8'd3 : 8'd2, 0, 0, 1, 0);
    end
`else
    // rst ld cen abt mode par | cnt co done busy lerr
    tbl.push_back(v(1,0,0,0,0,  0,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,  0,   0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,  5,   5,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   4,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   3,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   2,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,1,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    // auto-reload 3
    tbl.push_back(v(0,1,1,0,1,  3,   3,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   2,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   3,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   2,0,1,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   3,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   2,0,1,1,0));
    tbl.push_back(v(0,0,0,1,0,  0,   0,0,0,0,0));
    // zero load, idle cen
    tbl.push_back(v(0,1,0,0,0,  0,   0,0,0,0,1));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    // abort + ld at count 4
    tbl.push_back(v(0,1,0,0,0,  4,   4,0,0,1,0));
    tbl.push_back(v(0,1,1,1,1,  6,   0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    // ld on terminal edge
    tbl.push_back(v(0,1,1,0,0,  2,   2,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,1,1,0,0,  7,   7,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   6,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   5,0,0,1,0));
    // abort on terminal edge
    tbl.push_back(v(0,1,0,0,0,  1,   1,1,0,1,0));
    tbl.push_back(v(0,0,1,1,0,  0,   0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,  0,   0,0,0,0,0));
    // rst mid-run
    tbl.push_back(v(0,1,0,0,1,  9,   9,0,0,1,0));
    tbl.push_back(v(1,1,1,0,0,  3,   0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    // gapped cen
    tbl.push_back(v(0,1,0,0,0,  4,   4,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   3,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,  0,   3,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   2,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,  0,   2,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,0,0,0,0,  0,   1,1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0,   0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,  0,   0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,  0,   0,0,0,0,0));
    // maximum load
    tbl.push_back(v(0,1,1,0,0,255, 255,0,0,1,0));
    tbl.push_back(v(0,0,1,0,0,  0, 254,0,0,1,0));
    tbl.push_back(v(0,0,0,1,0,  0,   0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].cen,
            tbl[i].abort, tbl[i].mode, tbl[i].par);
      tick;
      check($sformatf("vec%0d", i), tbl[i].cnt,
            tbl[i].co, tbl[i].done, tbl[i].busy,
            tbl[i].lerr);
    end

    // auto-reload of 1: terminal every step
    drive(0, 1, 1, 0, 1, 1);
    tick;
    check("ar1_load", 1, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    tick;
    check("ar1_s1", 1, 1, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      tick;
      check($sformatf("ar1_s%0d", i), 1, 1, 1, 1, 0);
    end
    drive(0, 0, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick;

    // one-shot latency: done V+1 edges after the load edge
    begin
      int k;
      drive(0, 1, 1, 0, 0, 6);
      tick;
      drive(0, 0, 1, 0, 0, 0);
      k = 0;
      while (!done && k < 20) begin
        tick;
        k++;
      end
      n_vec++;
      if (k != 7) begin
        n_err++;
        $display("FAIL lat6: done after %0d edges, expected 7",
                 k);
      end
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_count_timer.md
# tx_count_timer

Parametrised loadable down-counter that paces the serial transmitter: it counts bit periods, flags the terminal count and reports completion. It sits between the transmitter control FSM and the shift register, and is the next generation of the fixed 8-bit counter. It adds generic width, one-shot/auto-reload modes, abort, load-error detection, a registered done pulse and an optional prescaler.

## Interface
- WIDTH, 8, counter and load-value width (≥2)
- PRESCALE, 4, cen events per count step when prescaler compiled in (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ld  input  1  load request, sampled at clk edge
- cen  input  1  count enable (one event per cycle high)
- abort  input  1  stop counting immediately
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled only on accepted ld
- par_ld  input  WIDTH  load value
- count  output  WIDTH  registered current count
- co  output  1  terminal count: high while RUN and count == 1 (combinational from registers)
- done  output  1  one-cycle registered pulse at each terminal step
- busy  output  1  high in RUN
- load_err  output  1  one-cycle registered pulse when ld with par_ld == 0

Clock is `clk`; reset is `rst`, synchronous and active-high.

## Operation
- States: IDLE, RUN.
- Internal registers: count, reload (WIDTH), mode_q, state, prescaler counter (macro only).
- Priority per edge: rst > abort > ld > step.
- rst: count=0, reload=0, mode_q=0, state=IDLE, done=0, load_err=0, prescaler=0.
- abort, any state: count=0, state=IDLE, prescaler=0, no done. reload and mode_q are kept.
- ld with par_ld≠0, any state: count=par_ld, reload=par_ld, mode_q=mode, prescaler=0, state=RUN. The cen step in that cycle is discarded.
- ld with par_ld==0: ignored. State and count are unchanged; load_err pulses next cycle.
- step = cen in RUN without macro; cen in RUN with prescaler at PRESCALE-1 with macro.
- Step in RUN with count>1: count−1.
- Step in RUN with count==1: done pulses next cycle. mode_q=1: count=reload, stay RUN. mode_q=0: count=0, go to IDLE.
- cen in IDLE: no effect. count never wraps below 0.
- co = busy && (count==1); low in IDLE regardless of count.
- Arithmetic is unsigned, WIDTH bits; the maximum load is 2^WIDTH−1.

## Timing
- Reset values: count=0, co=0, done=0, busy=0, load_err=0.
- ld accepted at edge N: count=par_ld and busy=1 visible after N.
- One-shot load of value V with cen held high:
  - co high during cycle N+V−1 (count==1).
  - done high during cycle N+V+1 (registered one cycle after the terminal edge).
  - busy low from edge N+V.
- Auto-reload: done pulses every V steps, and busy stays high.
- ld on the same edge as the terminal step: the load wins and done is not pulsed.
- abort on the same edge as the terminal step: abort wins and done is not pulsed.
- Sync rst mid-run takes effect at the next edge and overrides all other inputs.

## Configuration
- TX_CNT_PRESCALE_EN defined:
  - A $clog2(PRESCALE)-bit prescaler counts cen events in RUN.
  - A step occurs on the cen that completes PRESCALE events, after which the prescaler returns to 0.
  - The prescaler is cleared by rst, abort, accepted ld and the transition to IDLE.
- TX_CNT_PRESCALE_EN undefined: no prescaler logic; each cen in RUN is a step and PRESCALE is ignored.

## Test plan
- Reset, then one-shot: rst 2 cycles; ld, par_ld=5, mode=0, cen=1 -> count 5,4,3,2,1,0; co high only at count 1; single done pulse; busy low afterwards.
- Auto-reload: par_ld=3, mode=1, cen=1 for 10 cycles -> count 3,2,1,3,2,1…; done every 3 cycles; busy stays 1.
- Zero load and idle cen: ld, par_ld=0 -> load_err one pulse, busy 0, count 0; cen held in IDLE -> count stays 0, co 0.
- Priority collisions:
  - abort and ld in the same cycle at count=4 -> IDLE, count 0, no done.
  - ld par_ld=7 on the terminal-step edge -> count 7, no done.
  - rst mid-run -> all outputs 0.
- Gapped cen: par_ld=4, cen toggling 1,0,1,0 -> count changes only on cen cycles; done after the 4th cen.
- Prescaler (macro defined, PRESCALE=4): par_ld=2, cen=1 -> count changes every 4 cycles; done after 8 cen events; ld mid-prescale restarts the full 4-event window.
